// File: rtl/wb_write_arbiter_pkg.sv
// Shared constants and the queued write-back entry type for the write-back arbiter.
package wb_pkg;

  localparam logic [4:0]  REG_ZERO    = 5'd0;
  localparam logic [4:0]  REG_STATUS  = 5'd30;
  localparam logic [31:0] STATUS_MULT = 32'd4;
  localparam logic [31:0] STATUS_DIV  = 32'd5;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
    return 32'd1 << rd;
  endfunction

endpackage

// File: rtl/wb_write_arbiter_if.sv
// Multiply/divide result handshake into the write-back arbiter (valid/ready, one transfer per cycle).
interface wb_write_arbiter_if;

  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        md_exception;
  logic        md_is_div;

  modport master (
    output md_valid, md_rd, md_data, md_exception, md_is_div,
    input  md_ready
  );

  modport slave (
    input  md_valid, md_rd, md_data, md_exception, md_is_div,
    output md_ready
  );

endinterface

// File: rtl/wb_write_arbiter_fifo.sv
// Circular buffer of write-back entries with invalidate-by-destination and a pending mask.
// Push/pop take effect at the clock edge; the caller must not push when full or pop when empty.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic            clock,
  input  logic            ctrl_reset,
  input  logic            push_i,
  input  wb_entry_t       push_dat_i,
  input  logic            pop_i,
  output wb_entry_t       head_dat_o,
  input  logic            inv_vld_i,
  input  logic [4:0]      inv_rd_i,
  output logic [CW-1:0]   count_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [31:0]     pend_mask_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  wb_entry_t     ent_q [DEPTH];
  wb_entry_t     ent_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Invalidation only touches entries already queued; a same-cycle push is newer and survives.
  always_comb begin
    ent_d    = ent_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (inv_vld_i && ent_q[i].valid && (ent_q[i].rd == inv_rd_i)) begin
        ent_d[i].valid = 1'b0;
      end
    end
    if (pop_i) begin
      ent_d[rd_ptr_q].valid = 1'b0;
      rd_ptr_d              = ptr_inc(rd_ptr_q);
    end
    if (push_i) begin
      ent_d[wr_ptr_q] = push_dat_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ent_q    <= ent_d;
    end
  end

  always_comb begin
    pend_mask_o = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (ent_q[i].valid) begin
        pend_mask_o = pend_mask_o | rd_onehot(ent_q[i].rd);
      end
    end
  end

  assign head_dat_o = ent_q[rd_ptr_q];
  assign count_o    = count_q;
  assign full_o     = (count_q == FULL_CNT);
  assign empty_o    = (count_q == '0);

endmodule

// File: rtl/wb_write_arbiter.sv
// Merges pipeline write-back with buffered mul/div results into one registered regfile write port (1-cycle latency).
// Pipeline always wins the slot; mul/div is back-pressured via md_ready when the FIFO is full. WB_STATUS_EN redirects exceptions to r30.
module wb_write_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              pipe_we,
  input  logic [4:0]        pipe_rd,
  input  logic [31:0]       pipe_data,
  wb_write_arbiter_if.slave md,
  output logic              ctrl_writeEnable,
  output logic [4:0]        ctrl_writeReg,
  output logic [31:0]       data_writeReg,
  output logic [31:0]       pend_mask
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic          pipe_eff;
  logic          md_xfer;
  logic          md_keep;
  logic          pop;
  logic          direct;
  logic          push;
  wb_entry_t     md_entry;
  wb_entry_t     head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic [31:0]   fifo_mask;

  logic          we_q, we_d;
  logic [4:0]    wreg_q, wreg_d;
  logic [31:0]   wdata_q, wdata_d;

`ifdef WB_STATUS_EN
  always_comb begin
    md_entry.valid = 1'b1;
    md_entry.rd    = md.md_exception ? REG_STATUS : md.md_rd;
    md_entry.data  = md.md_exception ? (md.md_is_div ? STATUS_DIV : STATUS_MULT) : md.md_data;
  end
`else
  logic status_unused;
  assign status_unused = md.md_exception ^ md.md_is_div;
  always_comb begin
    md_entry.valid = 1'b1;
    md_entry.rd    = md.md_rd;
    md_entry.data  = md.md_data;
  end
`endif

  assign md.md_ready = ctrl_reset && (fifo_count != FULL_CNT);
  assign pipe_eff    = pipe_we && (pipe_rd != REG_ZERO);
  assign md_xfer     = md.md_valid && md.md_ready;
  // r0 results complete the handshake but are dropped here.
  assign md_keep     = md_xfer && (md_entry.rd != REG_ZERO);
  assign pop         = !pipe_eff && !fifo_empty;
  assign direct      = !pipe_eff && fifo_empty && md_keep;
  assign push        = md_keep && !direct && !fifo_full;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock       (clock),
    .ctrl_reset  (ctrl_reset),
    .push_i      (push),
    .push_dat_i  (md_entry),
    .pop_i       (pop),
    .head_dat_o  (head),
    .inv_vld_i   (pipe_eff),
    .inv_rd_i    (pipe_rd),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .pend_mask_o (fifo_mask)
  );

  // Address and data hold when idle or when an invalidated entry pops.
  always_comb begin
    we_d    = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    if (pipe_eff) begin
      we_d    = 1'b1;
      wreg_d  = pipe_rd;
      wdata_d = pipe_data;
    end else if (pop) begin
      if (head.valid) begin
        we_d    = 1'b1;
        wreg_d  = head.rd;
        wdata_d = head.data;
      end
    end else if (direct) begin
      we_d    = 1'b1;
      wreg_d  = md_entry.rd;
      wdata_d = md_entry.data;
    end
  end

  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      we_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
    end else begin
      we_q    <= we_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
    end
  end

  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = wreg_q;
  assign data_writeReg    = wdata_q;
  assign pend_mask        = ctrl_reset ? fifo_mask : '0;

endmodule

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

Write-back arbiter directly upstream of the processor's register file write port. It merges the single-cycle pipeline write-back stream with results from the multicycle multiply/divide unit. Multiply/divide results are buffered in a small FIFO until a free write slot exists. The block drives the register file's `ctrl_writeEnable`/`ctrl_writeReg`/`data_writeReg` from registers and exports a pending-destination mask for the stall logic.

## Interface
- `DEPTH`, 2: multiply/divide result FIFO entries (1..4).
- `clock` in 1: single clock; all state updates on rising edge.
- `ctrl_reset` in 1: synchronous, active-low reset.
- `pipe_we` in 1: pipeline write-back valid this cycle.
- `pipe_rd` in 5: pipeline destination register.
- `pipe_data` in 32: pipeline result.
- `md_valid` in 1: multiply/divide result valid.
- `md_ready` out 1: arbiter accepts the multiply/divide result this cycle.
- `md_rd` in 5: multiply/divide destination register.
- `md_data` in 32: multiply/divide result.
- `md_exception` in 1: overflow or divide-by-zero flagged with this result.
- `md_is_div` in 1: result came from a divide (1) or a multiply (0).
- `ctrl_writeEnable` out 1: register file write enable (registered).
- `ctrl_writeReg` out 5: register file write address (registered).
- `data_writeReg` out 32: register file write data (registered).
- `pend_mask` out 32: bit n set while the FIFO holds an entry targeting rn.

## Operation
- Effective pipeline write: `pipe_we && pipe_rd != 0`. A write to r0 is a no-op and leaves the slot free.
- Priority: an effective pipeline write always owns the output slot.
- Multiply/divide handshake:
  - A transfer occurs when `md_valid && md_ready`.
  - `md_ready = ctrl_reset && (count != DEPTH)`.
  - `md_valid` may drop without a transfer.
- Slot selection each cycle, in order:
  1. Effective pipeline write.
  2. Otherwise the FIFO head, if the FIFO is non-empty (popped).
  3. Otherwise the incoming multiply/divide transfer, if one occurs and the FIFO is empty (direct path, never enqueued).
  4. Otherwise the slot is idle and `ctrl_writeEnable = 0`.
- Any multiply/divide transfer not taken directly is pushed. Push and pop may occur in the same cycle.
- Multiply/divide entries with destination 0 are accepted and discarded: never enqueued, never written.
- Write-after-write: an effective pipeline write to rd X invalidates every queued entry with destination X. Invalidated entries still occupy a slot and pop without asserting a write.
- `pend_mask` is the OR of the one-hot destinations of valid queued entries. It is combinational from FIFO state.

## Timing
- Reset (`ctrl_reset=0` at an edge):
  - `ctrl_writeEnable=0`, `ctrl_writeReg=0`, `data_writeReg=0`.
  - FIFO emptied and in-flight queued entries lost.
  - `pend_mask=0` and `md_ready=0` while reset is asserted.
- Pipeline latency: 1 cycle from input to `ctrl_writeEnable`.
- Multiply/divide direct-path latency: 1 cycle.
- Queued entries: written in FIFO order, one per cycle without an effective pipeline write.
- Full FIFO: `md_ready=0`. A pop in that cycle does not raise `md_ready` until the next cycle.
- Outputs hold their last address and data when idle; only `ctrl_writeEnable` falls.

## Configuration
- `WB_STATUS_EN` defined: a result with `md_exception=1` is written to r30 instead of `md_rd`.
  - Written value: 32'd5 if `md_is_div`, else 32'd4.
  - The FIFO stores the rewritten destination and data.
- `WB_STATUS_EN` undefined: `md_exception` and `md_is_div` are ignored and the result goes to `md_rd` unchanged.

## Structure
- Package `wb_pkg` holds:
  - `REG_ZERO` = 0, `REG_STATUS` = 30.
  - `STATUS_MULT` = 4, `STATUS_DIV` = 5.
  - Struct `wb_entry_t` {valid, rd[4:0], data[31:0]}.
- Sub-module `wb_fifo`:
  - Parameterised circular buffer of `wb_entry_t`.
  - Ports: push/pop, count, full/empty.
  - Per-entry invalidate-by-rd input and a pending-mask output.
- Top level contains the slot mux, the output registers and the status rewrite.

## Test plan
- Reset then `pipe_we=1, pipe_rd=5, pipe_data=0x1234` -> next cycle `ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0x1234`. Before that cycle, all outputs are 0.
- FIFO empty, no pipeline write, md transfer rd=7 data=0xAA -> written next cycle, `pend_mask` stays 0.
- Pipeline writes every cycle for 4 cycles while md offers rd=8, then rd=9 (DEPTH=2):
  - Both are accepted; `pend_mask=0x300`; `md_ready=0` on a third offer.
  - After the pipeline goes idle: r8 is written, then r9 on consecutive cycles.
- Queued rd=12, then pipeline writes r12=0x55 -> r12 receives 0x55 only. The popped entry produces no write and bit 12 of `pend_mask` clears.
- Pipeline `pipe_rd=0` with a queued entry -> the queued entry drains that cycle. An md result with rd=0 is never written.
- `WB_STATUS_EN`, divide with `md_exception=1`, rd=3 -> r30 written with 5, r3 untouched. Without the macro, r3 is written with `md_data`.
